// File: rtl/scsi_fifo.sv
// scsi_fifo: 8 x 32-bit longword FIFO between the SCSI byte engine and the
// DMA/CPU longword bus. SCSI bytes are packed into / unpacked from longwords
// through a 2-bit byte pointer (BO, big-endian: BO=0 -> bits 31:24).
//
// Ports:
//   CLK, nRESET          clock, asynchronous active-low reset
//   FLUSH                synchronous clear of NI, NO, count, BO (data kept)
//   DMADIR               transfer direction, informational only
//   INCBO/INCNI/INCNO    SCSI-side pointer advances
//   S2F, SCSI_DIN        SCSI byte write into lane BO of entry NI
//   SCSI_DOUT            lane BO of entry NO
//   DMA_WR/BE/DIN        longword write into entry NI with byte enables
//   DMA_INCNI/INCNO      DMA-side pointer advances
//   DMA_DOUT             entry NO
//   FIFOEMPTY/FIFOFULL   count == 0 / count == 8
//   BOEQ3/BOEQ0          BO == 3 / BO == 0
//
// Optional macro SCSI_FIFO_ERR_EN adds sticky FIFO_OVF / FIFO_UNF outputs.
module scsi_fifo (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        FLUSH,
  input  logic        DMADIR,
  input  logic        INCBO,
  input  logic        INCNI,
  input  logic        INCNO,
  input  logic        S2F,
  input  logic [7:0]  SCSI_DIN,
  output logic [7:0]  SCSI_DOUT,
  input  logic        DMA_WR,
  input  logic [3:0]  DMA_BE,
  input  logic [31:0] DMA_DIN,
  input  logic        DMA_INCNI,
  input  logic        DMA_INCNO,
  output logic [31:0] DMA_DOUT,
  output logic        FIFOEMPTY,
  output logic        FIFOFULL,
  output logic        BOEQ3,
  output logic        BOEQ0
`ifdef SCSI_FIFO_ERR_EN
  ,
  output logic        FIFO_OVF,
  output logic        FIFO_UNF
`endif
);

  logic [31:0] mem_q [8];
  logic [31:0] mem_d [8];
  logic [2:0]  ni_q, ni_d, no_q, no_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  bo_q, bo_d;

  logic        incni, incno, full, empty, wr_ok;
  logic [31:0] be_mask, entry;
  logic        ovf_set, unf_set;

  // DMADIR has no effect on the symmetric datapath.
  logic unused_dmadir;
  assign unused_dmadir = DMADIR;

  assign incni = INCNI | DMA_INCNI;
  assign incno = INCNO | DMA_INCNO;
  assign full  = (cnt_q == 4'd8);
  assign empty = (cnt_q == 4'd0);
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_ok = ~full | incno;

  assign be_mask = {{8{DMA_BE[3]}}, {8{DMA_BE[2]}}, {8{DMA_BE[1]}}, {8{DMA_BE[0]}}};

  assign ovf_set = full & ~incno & (incni | S2F | DMA_WR);
  assign unf_set = empty & incno;

  always_comb begin
    mem_d = mem_q;
    ni_d  = ni_q;
    no_d  = no_q;
    cnt_d = cnt_q;
    bo_d  = bo_q;
    entry = mem_q[ni_q];
    if (FLUSH) begin
      ni_d  = '0;
      no_d  = '0;
      cnt_d = '0;
      bo_d  = '0;
    end else begin
      // DMA lanes first, then the SCSI byte overrides its lane.
      if (DMA_WR) entry = (entry & ~be_mask) | (DMA_DIN & be_mask);
      if (S2F)    entry[{~bo_q, 3'b000} +: 8] = SCSI_DIN;
      if (wr_ok && (DMA_WR || S2F)) mem_d[ni_q] = entry;

      if (INCBO) bo_d = bo_q + 2'd1;

      if (incni && incno) begin
        // At empty the pop is dropped; otherwise count is unchanged.
        ni_d = ni_q + 3'd1;
        if (empty) cnt_d = 4'd1;
        else       no_d  = no_q + 3'd1;
      end else if (incni && !full) begin
        ni_d  = ni_q + 3'd1;
        cnt_d = cnt_q + 4'd1;
      end else if (incno && !empty) begin
        no_d  = no_q + 3'd1;
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ni_q  <= '0;
      no_q  <= '0;
      cnt_q <= '0;
      bo_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      ni_q  <= ni_d;
      no_q  <= no_d;
      cnt_q <= cnt_d;
      bo_q  <= bo_d;
      mem_q <= mem_d;
    end
  end

`ifdef SCSI_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (FLUSH) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (ovf_set) ovf_d = 1'b1;
      if (unf_set) unf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign FIFO_OVF = ovf_q;
  assign FIFO_UNF = unf_q;
`else
  // Overflow and underflow are silently dropped.
  logic unused_err;
  assign unused_err = ovf_set | unf_set;
`endif

  assign SCSI_DOUT = mem_q[no_q][{~bo_q, 3'b000} +: 8];
  assign DMA_DOUT  = mem_q[no_q];
  assign FIFOEMPTY = empty;
  assign FIFOFULL  = full;
  assign BOEQ3     = (bo_q == 2'd3);
  assign BOEQ0     = (bo_q == 2'd0);

endmodule

// File: tb/tb_scsi_fifo.sv
module tb_scsi_fifo;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        FLUSH = 1'b0, DMADIR = 1'b0, INCBO = 1'b0, INCNI = 1'b0, INCNO = 1'b0;
  logic        S2F = 1'b0;
  logic [7:0]  SCSI_DIN = '0;
  logic [7:0]  SCSI_DOUT;
  logic        DMA_WR = 1'b0;
  logic [3:0]  DMA_BE = '0;
  logic [31:0] DMA_DIN = '0;
  logic        DMA_INCNI = 1'b0, DMA_INCNO = 1'b0;
  logic [31:0] DMA_DOUT;
  logic        FIFOEMPTY, FIFOFULL, BOEQ3, BOEQ0;
`ifdef SCSI_FIFO_ERR_EN
  logic        FIFO_OVF, FIFO_UNF;
`endif

  scsi_fifo dut (
    .CLK(CLK), .nRESET(nRESET), .FLUSH(FLUSH), .DMADIR(DMADIR),
    .INCBO(INCBO), .INCNI(INCNI), .INCNO(INCNO), .S2F(S2F),
    .SCSI_DIN(SCSI_DIN), .SCSI_DOUT(SCSI_DOUT),
    .DMA_WR(DMA_WR), .DMA_BE(DMA_BE), .DMA_DIN(DMA_DIN),
    .DMA_INCNI(DMA_INCNI), .DMA_INCNO(DMA_INCNO), .DMA_DOUT(DMA_DOUT),
    .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL), .BOEQ3(BOEQ3), .BOEQ0(BOEQ0)
`ifdef SCSI_FIFO_ERR_EN
    , .FIFO_OVF(FIFO_OVF), .FIFO_UNF(FIFO_UNF)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes held per entry in bus order (index 0 = MSB lane),
  // pointers derived from running push/pop totals.
  logic [7:0] m [8][4];
  int  tin, tout, mbo;
  bit  movf, munf;

  task automatic model_reset();
    tin = 0; tout = 0; mbo = 0; movf = 0; munf = 0;
    for (int e = 0; e < 8; e++)
      for (int l = 0; l < 4; l++) m[e][l] = 8'h00;
  endtask

  task automatic model_step();
    int cnt, ni;
    bit ii, io, ok;
    cnt = tin - tout;
    ni  = tin % 8;
    ii  = INCNI | DMA_INCNI;
    io  = INCNO | DMA_INCNO;
    if (FLUSH) begin
      tin = 0; tout = 0; mbo = 0; movf = 0; munf = 0;
    end else begin
      ok = (cnt < 8) || io;
      if (DMA_WR && ok)
        for (int l = 0; l < 4; l++)
          if (DMA_BE[3-l]) m[ni][l] = DMA_DIN[31-8*l -: 8];
      if (S2F && ok) m[ni][mbo] = SCSI_DIN;
      if (cnt == 8 && !io && (ii || S2F || DMA_WR)) movf = 1;
      if (io && cnt == 0) munf = 1;
      if (INCBO) mbo = (mbo + 1) % 4;
      if (ii && (cnt < 8 || io)) tin++;
      if (io && cnt > 0) tout++;
    end
  endtask

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) model_reset();
    else         model_step();
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    int h;
    h = tout % 8;
    chk("DMA_DOUT", DMA_DOUT, {m[h][0], m[h][1], m[h][2], m[h][3]});
    chk("SCSI_DOUT", {24'h0, SCSI_DOUT}, {24'h0, m[h][mbo]});
    chk("FIFOEMPTY", {31'h0, FIFOEMPTY}, {31'h0, (tin - tout) == 0});
    chk("FIFOFULL", {31'h0, FIFOFULL}, {31'h0, (tin - tout) == 8});
    chk("BOEQ3", {31'h0, BOEQ3}, {31'h0, mbo == 3});
    chk("BOEQ0", {31'h0, BOEQ0}, {31'h0, mbo == 0});
`ifdef SCSI_FIFO_ERR_EN
    chk("FIFO_OVF", {31'h0, FIFO_OVF}, {31'h0, movf});
    chk("FIFO_UNF", {31'h0, FIFO_UNF}, {31'h0, munf});
`endif
  end

  task automatic clear_strobes();
    FLUSH = 0; INCBO = 0; INCNI = 0; INCNO = 0; S2F = 0;
    DMA_WR = 0; DMA_INCNI = 0; DMA_INCNO = 0; DMA_BE = '0;
  endtask

  // Apply current inputs for one edge; returns 2 time units after it.
  task automatic tick();
    @(posedge CLK);
    #2;
    clear_strobes();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_DMA_DOUT"}, DMA_DOUT, 32'h0);
    chk({tag, "_SCSI_DOUT"}, {24'h0, SCSI_DOUT}, 32'h0);
    chk({tag, "_EMPTY"}, {31'h0, FIFOEMPTY}, 32'h1);
    chk({tag, "_FULL"}, {31'h0, FIFOFULL}, 32'h0);
    chk({tag, "_BOEQ0"}, {31'h0, BOEQ0}, 32'h1);
    chk({tag, "_BOEQ3"}, {31'h0, BOEQ3}, 32'h0);
  endtask

  logic [7:0] pk [4];
  logic [7:0] unp [4];

  initial begin
    pk  = '{8'h11, 8'h22, 8'h33, 8'h44};
    unp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    #3;
    chk_reset_outputs("reset");
    @(posedge CLK); #2;
    nRESET = 1;
    tick();

    // Byte packing
    DMADIR = 1;
    for (int i = 0; i < 4; i++) begin
      S2F = 1; SCSI_DIN = pk[i]; INCBO = 1;
      if (i == 3) INCNI = 1;
      tick();
    end
    chk("pack_dout", DMA_DOUT, 32'h11223344);
    chk("pack_empty", {31'h0, FIFOEMPTY}, 32'h0);
    chk("pack_boeq0", {31'h0, BOEQ0}, 32'h1);
    INCNO = 1; tick();

    // Byte unpacking
    DMADIR = 0;
    DMA_WR = 1; DMA_BE = 4'hF; DMA_DIN = 32'hA1B2C3D4; DMA_INCNI = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("unpack_byte", {24'h0, SCSI_DOUT}, {24'h0, unp[i]});
      INCBO = 1;
      if (i == 3) INCNO = 1;
      tick();
    end
    chk("unpack_empty", {31'h0, FIFOEMPTY}, 32'h1);

    // Full and wrap (NI/NO both start at 2 here)
    for (int i = 0; i < 8; i++) begin
      DMA_WR = 1; DMA_BE = 4'hF; DMA_DIN = 32'h1000_0000 + i; DMA_INCNI = 1;
      tick();
    end
    chk("full_set", {31'h0, FIFOFULL}, 32'h1);
    DMA_WR = 1; DMA_BE = 4'hF; DMA_DIN = 32'hDEADBEEF; DMA_INCNI = 1;
    tick();
    chk("full_hold", {31'h0, FIFOFULL}, 32'h1);
    chk("full_head", DMA_DOUT, 32'h1000_0000);
`ifdef SCSI_FIFO_ERR_EN
    chk("full_ovf", {31'h0, FIFO_OVF}, 32'h1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", DMA_DOUT, 32'h1000_0000 + i);
      INCNO = 1; tick();
    end
    chk("drain_empty", {31'h0, FIFOEMPTY}, 32'h1);

    // Simultaneous increments
    for (int i = 0; i < 8; i++) begin
      DMA_WR = 1; DMA_BE = 4'hF; DMA_DIN = 32'h2000_0000 + i; DMA_INCNI = 1;
      tick();
    end
    INCNI = 1; INCNO = 1; tick();
    chk("both_full", {31'h0, FIFOFULL}, 32'h1);
    chk("both_head", DMA_DOUT, 32'h2000_0001);
    FLUSH = 1; tick();
    chk("flush_empty", {31'h0, FIFOEMPTY}, 32'h1);
    INCNI = 1; DMA_INCNO = 1; tick();
    chk("both_empty_e", {31'h0, FIFOEMPTY}, 32'h0);
    chk("both_empty_f", {31'h0, FIFOFULL}, 32'h0);
`ifdef SCSI_FIFO_ERR_EN
    chk("both_unf", {31'h0, FIFO_UNF}, 32'h1);
    chk("flush_ovf", {31'h0, FIFO_OVF}, 32'h0);
`endif

    // Flush mid-transfer with BO=2, count=5
    FLUSH = 1; tick();
    for (int i = 0; i < 5; i++) begin
      DMA_INCNI = 1;
      if (i < 2) INCBO = 1;
      tick();
    end
    chk("pre_flush_boeq0", {31'h0, BOEQ0}, 32'h0);
    FLUSH = 1; INCBO = 1; INCNI = 1; S2F = 1; SCSI_DIN = 8'h5A; tick();
    chk("post_flush_empty", {31'h0, FIFOEMPTY}, 32'h1);
    chk("post_flush_boeq0", {31'h0, BOEQ0}, 32'h1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      FLUSH     = ($urandom_range(0, 63) == 0);
      DMADIR    = $urandom_range(0, 1);
      INCBO     = $urandom_range(0, 1);
      INCNI     = ($urandom_range(0, 3) == 0);
      INCNO     = ($urandom_range(0, 3) == 0);
      DMA_INCNI = ($urandom_range(0, 3) == 0);
      DMA_INCNO = ($urandom_range(0, 4) == 0);
      S2F       = $urandom_range(0, 1);
      SCSI_DIN  = 8'($urandom);
      DMA_WR    = $urandom_range(0, 1);
      DMA_BE    = 4'($urandom);
      DMA_DIN   = $urandom;
      tick();
    end

    // Reset pulse mid-write
    DMA_WR = 1; DMA_BE = 4'hF; DMA_DIN = 32'hCAFEF00D; DMA_INCNI = 1;
    tick();
    DMA_WR = 1; DMA_BE = 4'hF; DMA_DIN = 32'h12345678; DMA_INCNI = 1;
    #1;
    nRESET = 0;
    #1;
    chk_reset_outputs("midreset");
    clear_strobes();
    @(posedge CLK); #2;
    nRESET = 1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scsi_fifo.md
Name: scsi_fifo

Overview:
- 8-entry x 32-bit longword FIFO between the SCSI byte-transfer state machine and the DMA/CPU longword bus side of the SDMAC replacement.
- Packs SCSI bytes into longwords (SCSI->memory) and unpacks longwords into bytes (memory->SCSI), using a 2-bit byte pointer (BO).
- Maintains the next-in (NI) and next-out (NO) pointers and a fill count, and produces FIFOEMPTY, FIFOFULL and BOEQ3, which the SCSI state machine consumes.

Parameters:
- None. Depth is fixed at 8 entries and width at 32 bits; pointers are 3 bits, count is 4 bits, BO is 2 bits.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- nRESET  in  1  asynchronous active-low reset
- FLUSH  in  1  synchronous clear of pointers, count and BO
- DMADIR  in  1  1 = SCSI->memory (SCSI fills bytes); 0 = memory->SCSI (SCSI drains bytes)
- INCBO  in  1  SCSI side: advance byte pointer
- INCNI  in  1  SCSI side: advance next-in
- INCNO  in  1  SCSI side: advance next-out
- S2F  in  1  SCSI side: write SCSI_DIN into byte lane BO of entry NI
- SCSI_DIN  in  8  byte from SCSI IC
- SCSI_DOUT  out  8  byte lane BO of entry NO
- DMA_WR  in  1  write DMA_DIN into entry NI; byte lanes are selected by DMA_BE
- DMA_BE  in  4  byte enables; bit 3 = bits 31:24
- DMA_DIN  in  32  longword from DMA/CPU bus
- DMA_INCNI  in  1  DMA side: advance next-in
- DMA_INCNO  in  1  DMA side: advance next-out
- DMA_DOUT  out  32  entry NO (head longword)
- FIFOEMPTY  out  1  count == 0
- FIFOFULL  out  1  count == 8
- BOEQ3  out  1  BO == 3
- BOEQ0  out  1  BO == 0

Behaviour:
- **Reset.** Reset (nRESET low, asynchronous) sets NI=0, NO=0, count=0, BO=0 and clears all 8 entries to 0. Resulting outputs: FIFOEMPTY=1, FIFOFULL=0, BOEQ0=1, BOEQ3=0, DMA_DOUT=0, SCSI_DOUT=0.
- **Lane order.** Byte order is big-endian: BO=0 maps to bits 31:24, BO=1 to 23:16, BO=2 to 15:8, BO=3 to 7:0.
- **Combinational outputs.**
  - SCSI_DOUT = lane BO of entry NO.
  - DMA_DOUT = entry NO.
  - All flags are decoded directly from registers; there are no extra pipeline stages.
- **Merged increments.** incni = INCNI | DMA_INCNI and incno = INCNO | DMA_INCNO.
- **Writes.** Writes take effect at the clock edge and are visible on the outputs the following cycle.
  - S2F and DMA_WR asserted together: the DMA_WR lanes are written first, then the S2F lane overrides its byte.
  - A write into a full FIFO (count == 8) is ignored, unless incno is asserted in the same cycle.
- **Byte pointer.** INCBO: BO <= BO+1 mod 4, so BO wraps 3->0. BO is independent of NI/NO; the SCSI state machine pairs INCBO with INCNI or INCNO when BOEQ3.
- **Count update.**
  - incni only: count+1, NI+1 mod 8. Ignored when count == 8.
  - incno only: count-1, NO+1 mod 8. Ignored when count == 0.
  - incni and incno together: both pointers advance and count is unchanged, including when count == 8.
  - incni and incno together at count == 0: NI advances and count becomes 1; the incno is dropped (underflow).
- **Pointer wrap.** NI/NO wrap 7->0. count never exceeds 8 or goes below 0.
- **FLUSH.** Clears NI, NO, count and BO next edge; entry data is kept.
  - FLUSH has priority over all increments and writes in the same cycle.
- **DMADIR.** Used only for documentation and optional checking; the datapath is symmetric. DMADIR changes while count != 0 are legal but undefined in meaning; software flushes before turning direction around.

Optional Feature:
- Macro SCSI_FIFO_ERR_EN.
- When defined:
  - Adds output FIFO_OVF (1 bit): sticky set on incni while count == 8 without incno, or on a write while full.
  - Adds output FIFO_UNF (1 bit): sticky set on incno while count == 0.
  - Both are cleared by reset or FLUSH; reset value 0.
  - In the same cycle, FLUSH wins over set.
- When undefined: the ports are absent and errors are silently dropped as described above.

Test Plan:
- **Byte packing.** Reset, then DMADIR=1. Apply 4 S2F bytes 0x11,0x22,0x33,0x44 with INCBO each, and INCNI on the 4th (BOEQ3=1) -> DMA_DOUT=0x11223344, FIFOEMPTY=0, BO=0, BOEQ0=1.
- **Byte unpacking.** DMA_WR 0xA1B2C3D4 (BE=0xF) plus DMA_INCNI. Step INCBO 4 times with INCNO on BOEQ3 -> SCSI_DOUT sequence A1,B2,C3,D4, then FIFOEMPTY=1.
- **Full and wrap.** 8 DMA_WR+DMA_INCNI writes -> FIFOFULL=1 after the 8th. A 9th write is ignored (FIFO_OVF=1 if enabled). Then 8 INCNO reads return data in order, with NO wrapping 7->0.
- **Simultaneous increments.** At count=8, INCNI+INCNO together -> FIFOFULL stays 1 and both pointers advance. At count=0 with both -> count=1 and FIFOEMPTY=0.
- **Flush and reset mid-transfer.**
  - FLUSH with BO=2 and count=5 -> next cycle FIFOEMPTY=1, BO=0.
  - nRESET pulse mid-write -> all outputs take their reset values immediately.
